// File: rtl/bp_be_issue_fifo.sv
// Issue buffer between the frontend queue and the backend scheduler.
// Keeps write, speculative-read and commit pointers so issued entries can be replayed or flushed.
module bp_be_issue_fifo #(
  parameter int unsigned els_p        = 8,
  parameter int unsigned data_width_p = 128
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [data_width_p-1:0]     fe_queue_i,
  input  logic                        fe_queue_v_i,
  output logic                        fe_queue_ready_and_o,
  output logic [data_width_p-1:0]     deq_data_o,
  output logic                        deq_v_o,
  input  logic                        deq_yumi_i,
  input  logic                        commit_i,
  input  logic                        roll_i,
  input  logic                        clr_i,
  output logic                        empty_o,
  output logic [$clog2(els_p):0]      spec_cnt_o
);

  localparam int unsigned idx_w_lp = $clog2(els_p);
  localparam int unsigned ptr_w_lp = idx_w_lp + 1;

  logic [ptr_w_lp-1:0] wptr_r, rptr_spec_r, rptr_cmt_r;
  logic [ptr_w_lp-1:0] wptr_n, rptr_spec_n, rptr_cmt_n;
  logic [data_width_p-1:0] mem_r [els_p];

  logic full, enq, deq, commit_ok;

  // Full when the index bits match but the wrap bits differ
  assign full = (wptr_r[idx_w_lp-1:0] == rptr_cmt_r[idx_w_lp-1:0])
              & (wptr_r[idx_w_lp] != rptr_cmt_r[idx_w_lp]);

  assign fe_queue_ready_and_o = ~full & ~clr_i & ~reset_i;
  assign deq_v_o    = (rptr_spec_r != wptr_r) & ~roll_i & ~clr_i;
  assign deq_data_o = mem_r[rptr_spec_r[idx_w_lp-1:0]];
  assign empty_o    = (wptr_r == rptr_cmt_r);
  assign spec_cnt_o = wptr_r - rptr_spec_r;

  assign enq       = fe_queue_v_i & fe_queue_ready_and_o;
  assign deq       = deq_yumi_i & deq_v_o;
  assign commit_ok = commit_i & (rptr_cmt_r != rptr_spec_r);

  // Clear beats roll; roll restores to the post-commit checkpoint
  always_comb begin
    wptr_n      = wptr_r;
    rptr_spec_n = rptr_spec_r;
    rptr_cmt_n  = rptr_cmt_r;
    if (clr_i) begin
      rptr_spec_n = wptr_r;
      rptr_cmt_n  = wptr_r;
    end else begin
      if (enq)       wptr_n     = wptr_r + ptr_w_lp'(1);
      if (commit_ok) rptr_cmt_n = rptr_cmt_r + ptr_w_lp'(1);
      if (roll_i)    rptr_spec_n = rptr_cmt_n;
      else if (deq)  rptr_spec_n = rptr_spec_r + ptr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r      <= '0;
      rptr_spec_r <= '0;
      rptr_cmt_r  <= '0;
    end else begin
      wptr_r      <= wptr_n;
      rptr_spec_r <= rptr_spec_n;
      rptr_cmt_r  <= rptr_cmt_n;
    end
  end

  // Storage is not reset; contents are only observable behind valid pointers
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r[idx_w_lp-1:0]] <= fe_queue_i;
  end

endmodule

// File: tb/tb_bp_be_issue_fifo.sv
// Directed bench for bp_be_issue_fifo: fill, full+commit, clear, replay, wrap and async reset.
module tb_bp_be_issue_fifo;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b0;
  logic [127:0] fe_queue_i = '0;
  logic         fe_queue_v_i = 1'b0;
  logic         fe_queue_ready_and_o;
  logic [127:0] deq_data_o;
  logic         deq_v_o;
  logic         deq_yumi_i = 1'b0;
  logic         commit_i = 1'b0;
  logic         roll_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         empty_o;
  logic [3:0]   spec_cnt_o;

  int errors = 0;
  int checks = 0;

  bp_be_issue_fifo #(.els_p(8), .data_width_p(128)) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .fe_queue_i           (fe_queue_i),
    .fe_queue_v_i         (fe_queue_v_i),
    .fe_queue_ready_and_o (fe_queue_ready_and_o),
    .deq_data_o           (deq_data_o),
    .deq_v_o              (deq_v_o),
    .deq_yumi_i           (deq_yumi_i),
    .commit_i             (commit_i),
    .roll_i               (roll_i),
    .clr_i                (clr_i),
    .empty_o              (empty_o),
    .spec_cnt_o           (spec_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [127:0] pkt(input int i);
    return {32'hC0DE_0000, 64'h1234_5678_9ABC_DEF0, 32'(i)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle before sampling, still well before the next edge
  task automatic settle();
    #2;
  endtask

  initial begin
    // Reset
    #2 reset_i = 1'b1;
    settle();
    chk("rst_ready", 128'(fe_queue_ready_and_o), 128'(0));
    chk("rst_deq_v", 128'(deq_v_o), 128'(0));
    chk("rst_empty", 128'(empty_o), 128'(1));
    chk("rst_spec_cnt", 128'(spec_cnt_o), 128'(0));
    tick(); tick();
    reset_i = 1'b0;
    settle();
    chk("post_rst_ready", 128'(fe_queue_ready_and_o), 128'(1));

    // Fill: 8 back-to-back enqueues
    for (int i = 0; i < 8; i++) begin
      fe_queue_v_i = 1'b1; fe_queue_i = pkt(i);
      settle();
      chk($sformatf("fill_ready_%0d", i), 128'(fe_queue_ready_and_o), 128'(1));
      tick();
    end
    fe_queue_i = pkt(8);
    settle();
    chk("full_ready", 128'(fe_queue_ready_and_o), 128'(0));
    chk("full_empty", 128'(empty_o), 128'(0));
    chk("full_spec_cnt", 128'(spec_cnt_o), 128'(8));
    chk("full_head", deq_data_o, pkt(0));
    tick();
    settle();
    chk("full_hold_spec_cnt", 128'(spec_cnt_o), 128'(8));
    fe_queue_v_i = 1'b0;

    // Issue all 8 without committing
    for (int i = 0; i < 8; i++) begin
      deq_yumi_i = 1'b1;
      settle();
      chk($sformatf("issue_v_%0d", i), 128'(deq_v_o), 128'(1));
      chk($sformatf("issue_data_%0d", i), deq_data_o, pkt(i));
      tick();
    end
    deq_yumi_i = 1'b0;
    settle();
    chk("issued_deq_v", 128'(deq_v_o), 128'(0));
    chk("issued_ready", 128'(fe_queue_ready_and_o), 128'(0));

    // Full + commit: ready rises only on the following cycle
    commit_i = 1'b1; fe_queue_v_i = 1'b1; fe_queue_i = pkt(100);
    settle();
    chk("fc_ready_N", 128'(fe_queue_ready_and_o), 128'(0));
    tick();
    commit_i = 1'b0;
    settle();
    chk("fc_ready_N1", 128'(fe_queue_ready_and_o), 128'(1));
    tick();
    fe_queue_v_i = 1'b0;
    settle();
    chk("fc_new_v", 128'(deq_v_o), 128'(1));
    chk("fc_new_data", deq_data_o, pkt(100));
    chk("fc_spec_cnt", 128'(spec_cnt_o), 128'(1));

    // Clear wins over everything else
    clr_i = 1'b1; fe_queue_v_i = 1'b1; fe_queue_i = pkt(200);
    roll_i = 1'b1; commit_i = 1'b1; deq_yumi_i = 1'b1;
    settle();
    chk("clr_ready", 128'(fe_queue_ready_and_o), 128'(0));
    chk("clr_deq_v", 128'(deq_v_o), 128'(0));
    tick();
    clr_i = 1'b0; fe_queue_v_i = 1'b0; roll_i = 1'b0; commit_i = 1'b0; deq_yumi_i = 1'b0;
    settle();
    chk("clr_empty", 128'(empty_o), 128'(1));
    chk("clr_deq_v_after", 128'(deq_v_o), 128'(0));
    chk("clr_spec_cnt", 128'(spec_cnt_o), 128'(0));
    chk("clr_ready_after", 128'(fe_queue_ready_and_o), 128'(1));

    // Replay: enqueue 0..5, issue 0..3, commit 2, roll
    for (int i = 0; i < 6; i++) begin
      fe_queue_v_i = 1'b1; fe_queue_i = pkt(i);
      tick();
    end
    fe_queue_v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      deq_yumi_i = 1'b1;
      settle();
      chk($sformatf("rp_issue_%0d", i), deq_data_o, pkt(i));
      tick();
    end
    deq_yumi_i = 1'b0;
    commit_i = 1'b1;
    tick(); tick();
    commit_i = 1'b0;
    roll_i = 1'b1; deq_yumi_i = 1'b1;
    settle();
    chk("rp_roll_deq_v", 128'(deq_v_o), 128'(0));
    tick();
    roll_i = 1'b0; deq_yumi_i = 1'b0;
    settle();
    chk("rp_head", deq_data_o, pkt(2));
    chk("rp_spec_cnt", 128'(spec_cnt_o), 128'(4));
    for (int i = 2; i < 6; i++) begin
      deq_yumi_i = 1'b1;
      settle();
      chk($sformatf("rp_replay_%0d", i), deq_data_o, pkt(i));
      tick();
    end
    deq_yumi_i = 1'b0;
    commit_i = 1'b1;
    tick(); tick(); tick(); tick();
    commit_i = 1'b0;
    settle();
    chk("rp_empty", 128'(empty_o), 128'(1));

    // Wrap-around stream: enqueue t, issue t-1, commit t-2
    for (int t = 0; t < 22; t++) begin
      fe_queue_v_i = (t < 20);
      fe_queue_i   = pkt(t);
      deq_yumi_i   = (t >= 1 && t <= 20);
      commit_i     = (t >= 2);
      settle();
      if (t < 20) chk($sformatf("wr_ready_%0d", t), 128'(fe_queue_ready_and_o), 128'(1));
      if (t >= 1 && t <= 20) begin
        chk($sformatf("wr_v_%0d", t - 1), 128'(deq_v_o), 128'(1));
        chk($sformatf("wr_data_%0d", t - 1), deq_data_o, pkt(t - 1));
      end
      tick();
    end
    fe_queue_v_i = 1'b0; deq_yumi_i = 1'b0; commit_i = 1'b0;
    settle();
    chk("wr_empty", 128'(empty_o), 128'(1));

    // Async reset mid-cycle with 3 held entries
    for (int i = 0; i < 3; i++) begin
      fe_queue_v_i = 1'b1; fe_queue_i = pkt(50 + i);
      tick();
    end
    fe_queue_v_i = 1'b0;
    settle();
    chk("ar_pre_v", 128'(deq_v_o), 128'(1));
    #1 reset_i = 1'b1;
    #1;
    chk("ar_deq_v", 128'(deq_v_o), 128'(0));
    chk("ar_ready", 128'(fe_queue_ready_and_o), 128'(0));
    chk("ar_empty", 128'(empty_o), 128'(1));
    chk("ar_spec_cnt", 128'(spec_cnt_o), 128'(0));
    tick();
    reset_i = 1'b0;
    settle();
    chk("ar_rel_ready", 128'(fe_queue_ready_and_o), 128'(1));
    chk("ar_rel_empty", 128'(empty_o), 128'(1));
    fe_queue_v_i = 1'b1; fe_queue_i = pkt(77);
    tick();
    fe_queue_v_i = 1'b0;
    deq_yumi_i = 1'b1;
    settle();
    chk("ar_new_v", 128'(deq_v_o), 128'(1));
    chk("ar_new_data", deq_data_o, pkt(77));
    tick();
    deq_yumi_i = 1'b0; commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    settle();
    chk("ar_final_empty", 128'(empty_o), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
